// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified memory port between the instruction-fetch requester (IF)
//   and the load/store requester (MEM). MEM normally wins arbitration; a streak
//   counter lets IF through after MAX_MEM_STREAK consecutive MEM grants taken
//   while IF was waiting. A fetch can be cancelled by if_flush at any point; an
//   in-flight cancelled fetch still completes on the bus but is not reported.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   if_req/if_addr/if_flush  fetch request, address, cancel
//   if_rvalid/if_rdata       fetch completion pulse and instruction word
//   if_stall                 if_req & ~if_rvalid
//   mem_req/we/addr/wdata/be load/store request and operands
//   mem_rvalid/mem_rdata     load/store completion pulse and load data (0 for stores)
//   mem_stall                mem_req & ~mem_rvalid
//   bus_req/we/addr/wdata/be registered request towards the memory
//   bus_ready/bus_rdata      transfer completes in any cycle bus_ready is high
//   dbg_state_o              current FSM state (IDLE=0, BUSY_IF=1, BUSY_MEM=2)
//   dbg_streak_o             current MEM streak count
//
// Handshake: a requester raises x_req with stable operands and keeps them until
// the one-cycle x_rvalid pulse (IF may also abandon on if_flush). On the bus
// side bus_req and its operands stay constant until the cycle bus_ready is
// sampled high; that cycle completes the transfer and bus_req drops at its end.

module mem_port_arbiter #(
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  dbg_state_o,
    output logic [$clog2(MAX_MEM_STREAK+1)-1:0] dbg_streak_o
);

    localparam int SW = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_MEM_STREAK);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          drop_q;
    logic          if_rvalid_q;
    logic [31:0]   if_rdata_q;
    logic          mem_rvalid_q;
    logic [31:0]   mem_rdata_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_be_q;

    logic if_elig;
    logic mem_elig;
    logic grant_if;
    logic grant_mem;

    // Arbitration decision, only meaningful while IDLE. A requester is not
    // eligible in the cycle its own completion pulse is visible, which hands
    // the port to the other side right after each transfer.
    always_comb begin
        if_elig   = if_req & ~if_flush & ~if_rvalid_q;
        mem_elig  = mem_req & ~mem_rvalid_q;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        streak_d  = streak_q;
        if (state_q == IDLE) begin
            if ((streak_q == STREAK_MAX) && if_elig) begin
                grant_if = 1'b1;
            end else if (mem_elig) begin
                grant_mem = 1'b1;
            end else if (if_elig) begin
                grant_if = 1'b1;
            end

            // The streak only measures MEM wins taken while IF was waiting.
            if (grant_if || !if_elig) begin
                streak_d = '0;
            end else if (grant_mem && (streak_q != STREAK_MAX)) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            drop_q       <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rvalid_q <= 1'b0;
            mem_rdata_q  <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
        end else begin
            if_rvalid_q  <= 1'b0;
            mem_rvalid_q <= 1'b0;
            streak_q     <= streak_d;
            case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        state_q     <= BUSY_IF;
                        drop_q      <= 1'b0;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= 1'b0;
                        bus_addr_q  <= if_addr;
                        bus_wdata_q <= '0;
                        bus_be_q    <= 4'hF;
                    end else if (grant_mem) begin
                        state_q     <= BUSY_MEM;
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= mem_we;
                        bus_addr_q  <= mem_addr;
                        bus_wdata_q <= mem_wdata;
                        bus_be_q    <= mem_we ? mem_be : 4'hF;
                    end
                end
                BUSY_IF: begin
                    if (if_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (bus_ready) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        // A flush seen at any point of the transfer, including
                        // its last cycle, cancels the report.
                        if (!(drop_q || if_flush)) begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus_rdata;
                        end
                    end
                end
                BUSY_MEM: begin
                    if (bus_ready) begin
                        state_q      <= IDLE;
                        bus_req_q    <= 1'b0;
                        mem_rvalid_q <= 1'b1;
                        mem_rdata_q  <= bus_we_q ? 32'h0 : bus_rdata;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    bus_req_q <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving in the completion cycle hides the pulse immediately.
    assign if_rvalid    = if_rvalid_q & ~if_flush;
    assign if_rdata     = if_rdata_q;
    assign if_stall     = if_req & ~if_rvalid;
    assign mem_rvalid   = mem_rvalid_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_stall    = mem_req & ~mem_rvalid_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_be       = bus_be_q;
    assign dbg_state_o  = state_q;
    assign dbg_streak_o = streak_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MAX = 4;
  localparam int SW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          if_stall;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_be = '0;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          mem_stall;
  logic          bus_req;
  logic          bus_we;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [3:0]    bus_be;
  logic          bus_ready = 1'b0;
  logic [31:0]   bus_rdata = '0;
  logic [1:0]    dbg_state;
  logic [SW-1:0] dbg_streak;

  mem_port_arbiter #(.MAX_MEM_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state), .dbg_streak_o(dbg_streak)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // ---------------- bus responder ----------------
  int lat_fix = -1;
  int lat_cur = 0;
  int bcnt = 0;
  always begin
    @(posedge clk or posedge rst);
    #1;
    if (rst || !bus_req) begin
      bus_ready = 1'b0;
      bus_rdata = $urandom;
      bcnt      = 0;
      lat_cur   = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
    end else begin
      bus_ready = (bcnt == lat_cur);
      bus_rdata = (bcnt == lat_cur) ? mem_word(bus_addr) : $urandom;
      bcnt++;
    end
  end

  // ---------------- reference model ----------------
  // Transaction-level view: who owns the port, what was put on the bus, and
  // which completions are due. Evaluated mid-cycle with the inputs that the
  // next rising edge will sample.
  logic [31:0] if_exp_q[$];
  logic [31:0] mem_exp_q[$];
  int          m_owner = 0;    // 0 none, 1 fetch, 2 load/store
  int          m_streak = 0;
  bit          m_drop = 0;
  bit          m_ifrv = 0;
  bit          m_memrv = 0;
  bit          e_req = 0;
  bit          e_we = 0;
  logic [31:0] e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [3:0]  e_be = '0;

  always begin
    @(negedge clk or posedge rst);
    #2;
    if (rst) begin
      m_owner = 0; m_streak = 0; m_drop = 0; m_ifrv = 0; m_memrv = 0;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_be = '0;
      if_exp_q.delete();
      mem_exp_q.delete();
    end else begin
      bit n_ifrv;
      bit n_memrv;
      bit if_el;
      bit mem_el;
      int who;
      n_ifrv  = 0;
      n_memrv = 0;
      if (m_owner == 0) begin
        if_el  = if_req && !if_flush && !m_ifrv;
        mem_el = mem_req && !m_memrv;
        who = 0;
        if (m_streak == MAX && if_el) who = 1;
        else if (mem_el) who = 2;
        else if (if_el) who = 1;
        if (who == 1 || !if_el) m_streak = 0;
        else if (who == 2 && m_streak < MAX) m_streak = m_streak + 1;
        if (who == 1) begin
          e_req = 1; e_we = 0; e_addr = if_addr; e_wdata = '0; e_be = 4'hF;
          m_drop = 0;
        end else if (who == 2) begin
          e_req = 1; e_we = mem_we; e_addr = mem_addr; e_wdata = mem_wdata;
          e_be = mem_we ? mem_be : 4'hF;
        end
        m_owner = who;
      end else begin
        if (m_owner == 1 && if_flush) m_drop = 1;
        if (bus_ready) begin
          if (m_owner == 1) begin
            if (!m_drop) begin
              if_exp_q.push_back(mem_word(e_addr));
              n_ifrv = 1;
            end
            m_drop = 0;
          end else begin
            mem_exp_q.push_back(e_we ? 32'h0 : mem_word(e_addr));
            n_memrv = 1;
          end
          e_req   = 0;
          m_owner = 0;
        end
      end
      m_ifrv  = n_ifrv;
      m_memrv = n_memrv;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int n_chk = 0;
  int n_err = 0;
  bit end_chk = 0;

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always begin
    @(negedge clk or posedge rst);
    #1;
    if (rst) begin
      check("reset_bus", {bus_req, bus_we, bus_addr, bus_wdata, bus_be}, '0);
      check("reset_rvalid", {if_rvalid, mem_rvalid}, '0);
      check("reset_rdata", {if_rdata, mem_rdata}, '0);
      check("reset_streak", dbg_streak, '0);
    end else begin
      bit exp_ifrv;
      logic [31:0] d;
      exp_ifrv = m_ifrv && !if_flush;
      check("bus_req", bus_req, e_req);
      if (e_req) begin
        check("bus_addr", bus_addr, e_addr);
        check("bus_we_be", {bus_we, bus_be}, {e_we, e_be});
        check("bus_wdata", bus_wdata, e_wdata);
      end
      check("streak", dbg_streak, m_streak);
      check("if_rvalid", if_rvalid, exp_ifrv);
      check("mem_rvalid", mem_rvalid, m_memrv);
      check("if_stall", if_stall, if_req && !exp_ifrv);
      check("mem_stall", mem_stall, mem_req && !m_memrv);
      if (if_rvalid) begin
        if (if_exp_q.size() == 0) check("if_rvalid_unexpected", if_rvalid, 1'b0);
        else begin
          d = if_exp_q.pop_front();
          check("if_rdata", if_rdata, d);
        end
      end else if (m_ifrv && if_exp_q.size() > 0) begin
        // completion hidden by a flush in its pulse cycle (or already reported)
        d = if_exp_q.pop_front();
      end
      if (mem_rvalid) begin
        if (mem_exp_q.size() == 0) check("mem_rvalid_unexpected", mem_rvalid, 1'b0);
        else begin
          d = mem_exp_q.pop_front();
          check("mem_rdata", mem_rdata, d);
        end
      end else if (m_memrv && mem_exp_q.size() > 0) begin
        d = mem_exp_q.pop_front();
      end
      if (end_chk) begin
        check("if_q_left", if_exp_q.size(), 0);
        check("mem_q_left", mem_exp_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive(input int flush_pct);
    bit done_if;
    done_if = if_flush ? 1'b1 : if_rvalid;
    if (!if_req || done_if) begin
      if_req  = ($urandom_range(0, 99) < 60);
      if_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
    end
    if_flush = ($urandom_range(0, 99) < flush_pct);
    if (!mem_req || mem_rvalid) begin
      mem_req   = ($urandom_range(0, 99) < 50);
      mem_we    = $urandom_range(0, 1);
      mem_addr  = {16'h0001, 14'($urandom_range(0, 16383)), 2'b00};
      mem_wdata = $urandom;
      mem_be    = 4'($urandom_range(1, 15));
    end
  endtask

  task automatic wait_if_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (if_rvalid) begin
        if_req = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_mem_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (mem_rvalid) begin
        mem_req = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step();

    // fetch only, ready two cycles after bus_req
    lat_fix = 2;
    if_req = 1'b1; if_addr = 32'h100;
    wait_if_done(12);
    repeat (2) step();

    // contention: fetch and load in the same cycle, single-cycle bus
    lat_fix = 0;
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_be = 4'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_rvalid) mem_req = 1'b0;
      if (if_rvalid) if_req = 1'b0;
    end

    // both requesters held busy continuously
    lat_fix = -1;
    if_req = 1'b1; mem_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (if_rvalid) if_addr = if_addr + 32'd4;
      if (mem_rvalid) begin
        mem_addr = mem_addr + 32'd4;
        mem_we   = $urandom_range(0, 1);
        mem_wdata = $urandom;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    repeat (8) step();

    // flush while a fetch is in flight, then a normal fetch
    lat_fix = 3;
    if_req = 1'b1; if_addr = 32'h200;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_req) break;
    end
    if_flush = 1'b1;
    step();
    if_flush = 1'b0; if_req = 1'b0;
    repeat (6) step();
    if_req = 1'b1; if_addr = 32'h204;
    wait_if_done(12);
    repeat (2) step();

    // store
    lat_fix = 1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h3004;
    mem_wdata = 32'hDEAD_BEEF; mem_be = 4'b0011;
    wait_mem_done(12);
    mem_we = 1'b0;
    repeat (2) step();

    // randomized traffic
    lat_fix = -1;
    for (int i = 0; i < 2500; i++) begin
      step();
      rand_drive(5);
    end
    if_req = 1'b0; mem_req = 1'b0; if_flush = 1'b0;
    repeat (10) step();

    // asynchronous reset in the middle of a load
    lat_fix = 6;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_req) break;
    end
    step();
    #1 rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    mem_req = 1'b0;
    lat_fix = -1;
    repeat (10) step();

    end_chk = 1'b1;
    repeat (2) step();
    end_chk = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
